// File: rtl/i2s_pkg.sv
// ============================================================================
// Module   : i2s_pkg
// Purpose  : Shared types, defaults and helpers for the I2S capture path.
// Revision : 1.0
// ============================================================================
`default_nettype none

package i2s_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEEK  = 2'd1,
        LEFT  = 2'd2,
        RIGHT = 2'd3
    } state_t;

    localparam int c_DEF_BITSIZE   = 24;
    localparam int c_DEF_SLOT_BITS = 32;

    // Bits needed to hold values 0 .. value-1 (value >= 2).
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/i2s_lr_edge.sv
// ============================================================================
// Module   : i2s_lr_edge
// Purpose  : Registers lrclk and flags its rising/falling transitions.
// Revision : 1.0
// ============================================================================
`default_nettype none

module i2s_lr_edge (
    input  logic sclk,
    input  logic rst,
    input  logic i_lrclk,
    output logic o_rise,
    output logic o_fall,
    output logic o_edge
);

    logic r_lr_q;

    always_ff @(posedge sclk) begin
        if (rst) begin
            r_lr_q <= 1'b0;
        end else begin
            r_lr_q <= i_lrclk;
        end
    end

    assign o_rise = i_lrclk & ~r_lr_q;
    assign o_fall = ~i_lrclk & r_lr_q;
    assign o_edge = i_lrclk ^ r_lr_q;

endmodule

`default_nettype wire

// File: rtl/i2s_frame_ctrl.sv
// ============================================================================
// Module   : i2s_frame_ctrl
// Purpose  : Locks to I2S framing, checks slot lengths, emits L/R sample pairs.
// Revision : 1.0
// ============================================================================
`default_nettype none

module i2s_frame_ctrl
    import i2s_pkg::*;
#(
    parameter int BITSIZE   = c_DEF_BITSIZE,
    parameter int SLOT_BITS = c_DEF_SLOT_BITS
) (
    input  logic               sclk,
    input  logic               rst,
    input  logic               enable,
    input  logic               lrclk,
    input  logic               sdata,
    output logic [BITSIZE-1:0] left_chan,
    output logic [BITSIZE-1:0] right_chan,
    output logic               sample_valid,
    output logic               locked,
    output logic               frame_err,
    output logic [7:0]         err_count
);

    localparam int              c_CW   = clog2(SLOT_BITS);
    localparam logic [c_CW-1:0] c_LAST = c_CW'(SLOT_BITS - 1);

    logic w_rise;
    logic w_fall;
    logic w_edge;

    logic [c_CW-1:0]    r_cnt;
    logic [BITSIZE-1:0] r_shift;
    logic [BITSIZE-1:0] r_left_hold;
    logic [BITSIZE-1:0] r_left_chan;
    logic [BITSIZE-1:0] r_right_chan;
    logic               r_sample_valid;
    logic               r_locked;
    logic               r_frame_err;
    logic [7:0]         r_err_count;
    state_t             r_state;

    logic               w_capture;
    logic               w_slot_end;
    logic               w_overrun;
    logic               w_fault;
    logic [BITSIZE-1:0] w_shift_nxt;
    logic [BITSIZE-1:0] w_word;

    i2s_lr_edge u_lr_edge (
        .sclk    (sclk),
        .rst     (rst),
        .i_lrclk (lrclk),
        .o_rise  (w_rise),
        .o_fall  (w_fall),
        .o_edge  (w_edge)
    );

    // cnt equals the bit index of the sdata sampled this cycle.
    assign w_capture  = (32'(r_cnt) < 32'(BITSIZE));
    assign w_slot_end = (r_cnt == c_LAST);
    assign w_overrun  = !w_edge && w_slot_end;

    generate
        if (BITSIZE == 1) begin : g_shift_1
            assign w_shift_nxt = sdata;
        end else begin : g_shift_n
            assign w_shift_nxt = {r_shift[BITSIZE-2:0], sdata};
        end
    endgenerate

    // The closing edge-cycle may still carry the LSB when the slot is full width.
    assign w_word = w_capture ? w_shift_nxt : r_shift;

    assign w_fault = ((r_state == LEFT)  && ((w_rise && !w_slot_end) || w_overrun)) ||
                     ((r_state == RIGHT) && ((w_fall && !w_slot_end) || w_overrun));

    always_ff @(posedge sclk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_shift <= '0;
        end else begin
            r_cnt <= w_edge ? '0 : r_cnt + 1'b1;
            if (w_capture) begin
                r_shift <= w_shift_nxt;
            end
        end
    end

    always_ff @(posedge sclk) begin
        if (rst) begin
            r_state        <= IDLE;
            r_left_hold    <= '0;
            r_left_chan    <= '0;
            r_right_chan   <= '0;
            r_sample_valid <= 1'b0;
            r_frame_err    <= 1'b0;
            r_locked       <= 1'b0;
            r_err_count    <= 8'd0;
        end else begin
            r_sample_valid <= 1'b0;
            r_frame_err    <= 1'b0;
            if (!enable) begin
                r_state  <= IDLE;
                r_locked <= 1'b0;
            end else if (w_fault) begin
                r_state     <= SEEK;
                r_locked    <= 1'b0;
                r_frame_err <= 1'b1;
                if (r_err_count != 8'hFF) begin
                    r_err_count <= r_err_count + 8'd1;
                end
            end else begin
                case (r_state)
                    IDLE: begin
                        r_state  <= SEEK;
                        r_locked <= 1'b0;
                    end
                    SEEK: begin
                        if (w_fall) begin
                            r_state  <= LEFT;
                            r_locked <= 1'b1;
                        end
                    end
                    LEFT: begin
                        if (w_rise) begin
                            r_left_hold <= w_word;
                            r_state     <= RIGHT;
                        end
                    end
                    RIGHT: begin
                        if (w_fall) begin
                            r_left_chan    <= r_left_hold;
                            r_right_chan   <= w_word;
                            r_sample_valid <= 1'b1;
                            r_state        <= LEFT;
                        end
                    end
                endcase
            end
        end
    end

    assign left_chan    = r_left_chan;
    assign right_chan   = r_right_chan;
    assign sample_valid = r_sample_valid;
    assign locked       = r_locked;
    assign frame_err    = r_frame_err;
    assign err_count    = r_err_count;

endmodule

`default_nettype wire

// File: tb/tb_i2s_frame_ctrl.sv
// ============================================================================
// Module   : tb_i2s_frame_ctrl
// Purpose  : Directed self-checking bench for i2s_frame_ctrl (24- and 32-bit).
// Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_i2s_frame_ctrl;

    localparam logic [31:0] c_L  = 32'hABCDEF00;
    localparam logic [31:0] c_R  = 32'h12345600;
    localparam logic [31:0] c_X  = 32'h5A5A5A00;
    localparam logic [31:0] c_FL = 32'h80000001;
    localparam logic [31:0] c_FR = 32'hFFFFFFFE;

    logic sclk = 1'b0;
    logic rst, enable, lrclk, sdata;
    logic prev_lsb;

    logic [23:0] left24, right24;
    logic [31:0] left32, right32;
    logic        valid24, locked24, err24;
    logic        valid32, locked32, err32;
    logic [7:0]  cnt24, cnt32;

    int cyc = 0;
    int n_checks = 0;
    int n_errors = 0;
    int n_valid, n_err, first_valid, last_valid, bad_gap, last_err, err_locked;
    int s, f2;

    always #5 sclk = ~sclk;

    i2s_frame_ctrl #(.BITSIZE(24), .SLOT_BITS(32)) u_dut24 (
        .sclk         (sclk),
        .rst          (rst),
        .enable       (enable),
        .lrclk        (lrclk),
        .sdata        (sdata),
        .left_chan    (left24),
        .right_chan   (right24),
        .sample_valid (valid24),
        .locked       (locked24),
        .frame_err    (err24),
        .err_count    (cnt24)
    );

    i2s_frame_ctrl #(.BITSIZE(32), .SLOT_BITS(32)) u_dut32 (
        .sclk         (sclk),
        .rst          (rst),
        .enable       (enable),
        .lrclk        (lrclk),
        .sdata        (sdata),
        .left_chan    (left32),
        .right_chan   (right32),
        .sample_valid (valid32),
        .locked       (locked32),
        .frame_err    (err32),
        .err_count    (cnt32)
    );

    always @(posedge sclk) cyc = cyc + 1;

    // Event recorder for the 24-bit instance; cyc labels the edge just taken.
    always @(negedge sclk) begin
        if (valid24) begin
            n_valid = n_valid + 1;
            if (first_valid < 0) first_valid = cyc;
            if (last_valid >= 0 && (cyc - last_valid) != 64) bad_gap = bad_gap + 1;
            last_valid = cyc;
        end
        if (err24) begin
            n_err    = n_err + 1;
            last_err = cyc;
            if (locked24) err_locked = err_locked + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge sclk);
        #1;
    endtask

    task automatic clear_mon();
        n_valid     = 0;
        n_err       = 0;
        first_valid = -1;
        last_valid  = -1;
        bad_gap     = 0;
        last_err    = -1;
        err_locked  = 0;
    endtask

    // One slot of len cycles; first cycle is the edge-cycle carrying the previous LSB.
    task automatic drive_slot(input logic lr, input logic [31:0] w, input int len, output int start);
        start = 0;
        for (int i = 0; i < len; i++) begin
            step();
            if (i == 0) start = cyc;
            lrclk = lr;
            if (i == 0)       sdata = prev_lsb;
            else if (i <= 32) sdata = w[32 - i];
            else              sdata = 1'b0;
        end
        prev_lsb = w[0];
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; lrclk = 1'b1; sdata = 1'b0; prev_lsb = 1'b0;
        clear_mon();
        repeat (3) step();
        chk("rst_left",   32'(left24),  32'h0);
        chk("rst_right",  32'(right24), 32'h0);
        chk("rst_valid",  32'(valid24), 32'h0);
        chk("rst_err",    32'(err24),   32'h0);
        chk("rst_locked", 32'(locked24), 32'h0);
        chk("rst_count",  32'(cnt24),   32'h0);
        rst = 1'b0;
        step();
        enable = 1'b1;
        repeat (4) step();

        // Nominal locking
        clear_mon();
        drive_slot(1'b0, c_L, 32, s);
        drive_slot(1'b1, c_R, 32, s);
        drive_slot(1'b0, c_L, 32, f2);
        drive_slot(1'b1, c_R, 32, s);
        drive_slot(1'b0, c_L, 32, s);
        drive_slot(1'b1, c_R, 32, s);
        drive_slot(1'b0, c_L, 32, s);
        chk("nom_nvalid",  n_valid, 3);
        chk("nom_first",   first_valid, f2 + 1);
        chk("nom_gap",     bad_gap, 0);
        chk("nom_left",    32'(left24),  32'hABCDEF);
        chk("nom_right",   32'(right24), 32'h123456);
        chk("nom_left32",  left32,  c_L);
        chk("nom_right32", right32, c_R);
        chk("nom_count",   32'(cnt24), 0);
        chk("nom_locked",  32'(locked24), 1);

        // Short left slot
        clear_mon();
        drive_slot(1'b1, c_R, 32, s);
        drive_slot(1'b0, c_X, 31, s);
        drive_slot(1'b1, c_R, 32, f2);
        drive_slot(1'b0, c_L, 32, f2);
        drive_slot(1'b1, c_R, 32, f2);
        drive_slot(1'b0, c_L, 32, f2);
        chk("short_nerr",   n_err, 1);
        chk("short_errcyc", last_err, s + 32);
        chk("short_unlock", err_locked, 0);
        chk("short_count",  32'(cnt24), 1);
        chk("short_nvalid", n_valid, 2);
        chk("short_relock", 32'(locked24), 1);

        // Long right slot
        clear_mon();
        drive_slot(1'b1, c_X, 33, s);
        drive_slot(1'b0, c_L, 32, f2);
        chk("long_nerr",   n_err, 1);
        chk("long_errcyc", last_err, s + 33);
        chk("long_nvalid", n_valid, 0);
        chk("long_right",  32'(right24), 32'h123456);
        chk("long_left",   32'(left24),  32'hABCDEF);
        drive_slot(1'b1, c_R, 32, s);
        drive_slot(1'b0, c_L, 32, s);
        chk("long_relock", n_valid, 1);
        chk("long_count",  32'(cnt24), 2);

        // Full-width capture
        clear_mon();
        drive_slot(1'b1, c_R,  32, s);
        drive_slot(1'b0, c_FL, 32, s);
        drive_slot(1'b1, c_FR, 32, s);
        drive_slot(1'b0, c_L,  32, s);
        chk("full_left32",  left32,  c_FL);
        chk("full_right32", right32, c_FR);
        chk("full_left24",  32'(left24),  32'h800000);
        chk("full_right24", 32'(right24), 32'hFFFFFF);
        chk("full_nvalid",  n_valid, 2);

        // Enable dropped mid-RIGHT
        clear_mon();
        drive_slot(1'b1, c_R, 10, s);
        enable = 1'b0;
        drive_slot(1'b1, c_R, 22, s);
        drive_slot(1'b0, c_L, 32, s);
        drive_slot(1'b1, c_R, 32, s);
        chk("en_nvalid", n_valid, 0);
        chk("en_nerr",   n_err, 0);
        chk("en_locked", 32'(locked24), 0);
        chk("en_hold",   32'(left24), 32'h800000);
        enable = 1'b1;
        drive_slot(1'b0, c_L, 32, s);
        drive_slot(1'b1, c_R, 32, s);
        drive_slot(1'b0, c_L, 32, s);
        chk("en_relock", n_valid, 1);
        chk("en_left",   32'(left24), 32'hABCDEF);

        // Reset mid-LEFT
        drive_slot(1'b1, c_R, 32, s);
        drive_slot(1'b0, c_L, 10, s);
        rst = 1'b1;
        step();
        chk("mrst_left",   32'(left24),  32'h0);
        chk("mrst_right",  32'(right24), 32'h0);
        chk("mrst_locked", 32'(locked24), 0);
        chk("mrst_count",  32'(cnt24), 0);
        chk("mrst_valid",  32'(valid24), 0);
        rst = 1'b0;

        // Error saturation
        clear_mon();
        for (int k = 0; k < 300; k++) begin
            drive_slot(1'b1, c_R, 2, s);
            drive_slot(1'b0, c_L, 31, s);
        end
        drive_slot(1'b1, c_R, 2, s);
        repeat (3) step();
        chk("sat_count24", 32'(cnt24), 255);
        chk("sat_count32", 32'(cnt32), 255);
        chk("sat_nerr",    n_err, 300);
        chk("sat_nvalid",  n_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/i2s_frame_ctrl.md
# i2s_frame_ctrl

Frame controller for the codec-to-FPGA I2S capture path, running in the bit-clock domain. It locks onto the `lrclk` framing and checks every half-frame length. It extracts the first BITSIZE bits of each slot MSB-first and presents left/right sample pairs with a one-cycle valid strobe. On any framing fault it reports the fault and re-synchronises, so downstream audio blocks only ever see whole, correctly aligned frames.

## Interface
- BITSIZE, 24: sample width taken from each slot; 1 ≤ BITSIZE ≤ SLOT_BITS.
- SLOT_BITS, 32: required `sclk` cycles per half-frame (one channel slot); ≥ 2.
- sclk  in  1  bit clock, the only clock; all logic on rising edge.
- rst  in  1  reset; synchronous, active-high.
- enable  in  1  capture enable; low forces IDLE.
- lrclk  in  1  word select; low = left slot, high = right slot.
- sdata  in  1  serial data, MSB first, one-bit I2S delay after `lrclk` change.
- left_chan  out  BITSIZE  last complete left sample.
- right_chan  out  BITSIZE  last complete right sample.
- sample_valid  out  1  one-cycle pulse; `left_chan`/`right_chan` updated this cycle.
- locked  out  1  high in LEFT or RIGHT state.
- frame_err  out  1  one-cycle pulse on framing fault.
- err_count  out  8  saturating count of `frame_err` pulses.

## Operation
- `lr_q` is `lrclk` registered each cycle.
- Edge-cycle = `lrclk != lr_q`.
  - Rise = `lrclk` 1 and `lr_q` 0.
  - Fall = `lrclk` 0 and `lr_q` 1.
- Slot counter `cnt`, width clog2(SLOT_BITS):
  - Loaded with 0 on every edge-cycle.
  - Otherwise increments.
  - Sampled at cycle E+j, `cnt` = j-1, which equals the bit position of the `sdata` sampled that cycle.
- Shift register captures `sdata` while `cnt` < BITSIZE, including edge-cycles.
  - Latched words use {shift register, current `sdata`} when the current cycle is itself a capture cycle.
  - When BITSIZE = SLOT_BITS, the LSB arrives on the closing edge-cycle.
- States:
  - IDLE
    - Entered on reset or `enable`=0; `locked`=0.
    - `enable`=1 → SEEK.
  - SEEK: wait for a Fall, then load `cnt`=0 → LEFT. Rises are ignored.
  - LEFT, on a Rise:
    - `cnt` = SLOT_BITS-1: latch the captured word into internal `left_hold` → RIGHT.
    - Otherwise: error.
  - RIGHT, on a Fall:
    - `cnt` = SLOT_BITS-1: `left_chan`←`left_hold`, `right_chan`←captured word, pulse `sample_valid` → LEFT.
    - Otherwise: error.
  - LEFT/RIGHT overrun: a non-edge cycle with `cnt` = SLOT_BITS-1 means the slot is too long → error immediately.
- Error handling:
  - Pulse `frame_err`, increment `err_count` (saturate at 255), go to SEEK.
  - No `sample_valid` is issued and the pending `left_hold` is discarded.
  - The edge-cycle that caused the error is not reused as a SEEK Fall; lock requires a later Fall.
- `enable` low in any state → IDLE next cycle with no `sample_valid` and no `frame_err`.
- Precedence: `rst` > `enable`=0 > error > normal transition.
- `left_chan`/`right_chan` hold their last values through errors, IDLE and re-lock.

## Timing
- Reset values:
  - `left_chan`, `right_chan` = 0.
  - `sample_valid`, `frame_err`, `locked` = 0.
  - `err_count` = 0, `lr_q` = 0, state = IDLE.
- All outputs are registered. A Fall on cycle E gives `sample_valid` high for exactly cycle E+1, with new data valid in the same cycle.
- `frame_err` is visible on the cycle after the detecting cycle.
- After a clean Fall in SEEK:
  - The first `sample_valid` follows 2×SLOT_BITS cycles later (+1 register).
  - In steady state, one pulse every 2×SLOT_BITS cycles.
- `locked` rises the cycle after the locking Fall and falls the cycle after an error or `enable`=0.
- Reset mid-frame: all state is cleared on the next edge; the partial frame is never emitted.

## Structure
- Package `i2s_pkg`:
  - state enum (IDLE, SEEK, LEFT, RIGHT);
  - default BITSIZE/SLOT_BITS constants;
  - counter-width function clog2.
- One sub-module, `i2s_lr_edge`: registers `lrclk` and outputs rise/fall/edge strobes, with synchronous `rst`.
- The FSM, counter, shift register and output registers stay in `i2s_frame_ctrl`.

## Test plan
- Nominal locking:
  - Stimulus: BITSIZE=24, SLOT_BITS=32, `enable`=1, standard frames with left=0xABCDEF, right=0x123456.
  - Required: first `sample_valid` one cycle after the second Fall; `left_chan`=0xABCDEF, `right_chan`=0x123456; then one pulse every 64 cycles; `err_count`=0.
- Short slot: a left slot of 31 cycles → `frame_err` pulse, `locked`=0, no `sample_valid` for that frame, `err_count`=1; re-locks on the next Fall.
- Long slot: a right slot held 33 cycles → `frame_err` on the overrun cycle before the late Fall, no valid; outputs retain the prior pair.
- Full-width capture:
  - Stimulus: BITSIZE=SLOT_BITS=32, LSB driven on the edge-cycle, left=0x80000001, right=0xFFFFFFFE.
  - Required: exact match on both channels.
- Control events:
  - `enable` dropped in the middle of RIGHT → IDLE, no pulses.
  - `rst` asserted mid-LEFT → all outputs 0 next cycle.
- Error saturation: 300 consecutive bad frames → `err_count` stops at 255.
